// File: rtl/noc_pkg.sv
// Shared definitions for the ring NoC network-interface blocks.
//   NODE_ID_W    : width of a node id on the 4-node ring
//   DEST_MSB/LSB : destination field inside a 16-bit ring flit
//   PAYLOAD_MSB  : top bit of the payload field (payload ends at bit 0)
//   inj_state_t  : injector flow-control states
package noc_pkg;

  localparam int unsigned NODE_ID_W   = 2;
  localparam int unsigned FLIT_W      = 16;
  localparam int unsigned DEST_MSB    = FLIT_W - 1;
  localparam int unsigned DEST_LSB    = FLIT_W - NODE_ID_W;
  localparam int unsigned PAYLOAD_MSB = DEST_LSB - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2,
    GAP  = 2'd3
  } inj_state_t;

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO holding pre-packed flits for the injector.
//   clk, reset : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   o_head     : current head entry
//   o_count    : occupancy, 0..DEPTH
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
module noc_fifo #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDWIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic [WIDTH-1:0]    i_data,
  input  logic                i_pop,
  output logic [WIDTH-1:0]    o_head,
  output logic [ADDWIDTH:0]   o_count,
  output logic                o_full,
  output logic                o_empty
);

  localparam logic [ADDWIDTH:0] DepthCnt = (ADDWIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDWIDTH-1:0] r_wptr;
  logic [ADDWIDTH-1:0] r_rptr;
  logic [ADDWIDTH:0]   r_count;
  logic                w_push;
  logic                w_pop;

  assign o_full  = (r_count == DepthCnt);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/noc_injector.sv
// Network interface feeding one local port of the 4-node ring NoC.
// Buffers {dest, payload} flits and injects them with a burst limit.
//   clk, reset       : clock, asynchronous active-low reset
//   in_valid/ready   : producer handshake; in_dest/in_data form the flit
//   write, dataOut   : registered strobe and flit to the NoC local port
//   full/almost_full : NoC local port flow control
//   fifo_count       : local FIFO occupancy
//   sent_count       : flits injected since reset, saturating
module noc_injector
  import noc_pkg::*;
#(
  parameter int unsigned          WIDTH     = 16,
  parameter int unsigned          DEPTH     = 8,
  parameter int unsigned          ADDWIDTH  = 3,
  parameter logic [NODE_ID_W-1:0] NODE_ID   = 2'b00,
  parameter int unsigned          MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NODE_ID_W-1:0]   in_dest,
  input  logic [WIDTH-NODE_ID_W-1:0] in_data,
  output logic                   write,
  output logic [WIDTH-1:0]       dataOut,
  input  logic                   full,
  input  logic                   almost_full,
  output logic [ADDWIDTH:0]      fifo_count,
  output logic [15:0]            sent_count
);

  localparam logic [3:0] BurstMax = 4'(MAX_BURST);

  logic [WIDTH-1:0]  w_flit;
  logic [WIDTH-1:0]  w_head;
  logic [ADDWIDTH:0] w_count;
  logic              w_fifo_full;
  logic              w_empty;
  logic              w_push;
  logic              w_go;
  logic [3:0]        w_burst_inc;
  logic [3:0]        w_burst_d;
  inj_state_t        w_state_d;

  inj_state_t        r_state;
  logic [3:0]        r_burst;
  logic              r_write;
  logic [WIDTH-1:0]  r_data;
  logic [15:0]       r_sent;

  // FIFO full is exactly count == DEPTH; never depends on this cycle's pop.
  assign in_ready    = !w_fifo_full;
  assign w_push      = in_valid && in_ready;
  assign w_flit      = {in_dest, in_data};
  // almost_full stops us because write is registered; full is a backstop.
  assign w_go        = !w_empty && !full && !almost_full && (r_state != GAP);
  assign w_burst_inc = r_burst + 4'd1;

  noc_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDWIDTH (ADDWIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_flit),
    .i_pop   (w_go),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_d = r_state;
    w_burst_d = r_burst;
    if (w_go) begin
      if (w_burst_inc == BurstMax) begin
        w_state_d = GAP;
        w_burst_d = '0;
      end else begin
        w_state_d = SEND;
        w_burst_d = w_burst_inc;
      end
    end else begin
      case (r_state)
        IDLE: if (!w_empty) w_state_d = HOLD;
        SEND: begin
          if (w_empty) begin
            w_state_d = IDLE;
            w_burst_d = '0;
          end else begin
            w_state_d = HOLD;
          end
        end
        HOLD: w_state_d = HOLD;
        GAP:  w_state_d = w_empty ? IDLE : SEND;
        default: begin
          w_state_d = IDLE;
          w_burst_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_burst <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_sent  <= '0;
    end else begin
      r_state <= w_state_d;
      r_burst <= w_burst_d;
      r_write <= w_go;
      if (w_go) r_data <= w_head;
      if (w_go && (r_sent != 16'hFFFF)) r_sent <= r_sent + 16'd1;
    end
  end

  assign write      = r_write;
  assign dataOut    = r_data;
  assign fifo_count = w_count;
  assign sent_count = r_sent;

  // Words addressed to this node take the normal path; the ring loops them back.
  a_local_accept: assert property (@(posedge clk) disable iff (!reset)
    (w_push && (in_dest == NODE_ID)) |=> (w_count != '0));

endmodule

// File: tb/tb_noc_injector.sv
module tb_noc_injector;
  import noc_pkg::*;

  localparam int SatTarget = 65540;
  localparam int SatBudget = 75000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_dest = '0;
  logic [13:0] in_data = '0;
  logic        write;
  logic [15:0] dataOut;
  logic        full = 1'b0;
  logic        almost_full = 1'b0;
  logic [3:0]  fifo_count;
  logic [15:0] sent_count;

  // Second instance with the widest burst, used only for counter saturation.
  logic        s_reset = 1'b0;
  logic        s_in_valid = 1'b1;
  logic        s_in_ready;
  logic [1:0]  s_in_dest = 2'd1;
  logic [13:0] s_in_data = 14'h0155;
  logic        s_write;
  logic [15:0] s_dataOut;
  logic        s_full = 1'b0;
  logic        s_almost_full = 1'b0;
  logic [3:0]  s_fifo_count;
  logic [15:0] s_sent_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic sat_done = 1'b0;

  always #5 clk = ~clk;

  noc_injector #(
    .WIDTH(16), .DEPTH(8), .ADDWIDTH(3), .NODE_ID(2'b00), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .write(write), .dataOut(dataOut),
    .full(full), .almost_full(almost_full), .fifo_count(fifo_count),
    .sent_count(sent_count)
  );

  noc_injector #(
    .WIDTH(16), .DEPTH(8), .ADDWIDTH(3), .NODE_ID(2'b01), .MAX_BURST(15)
  ) dut_sat (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_dest(s_in_dest), .in_data(s_in_data), .write(s_write), .dataOut(s_dataOut),
    .full(s_full), .almost_full(s_almost_full), .fifo_count(s_fifo_count),
    .sent_count(s_sent_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put_word(input logic [1:0] dest, input logic [13:0] data, output logic acc);
    in_valid = 1'b1;
    in_dest  = dest;
    in_data  = data;
    acc = in_ready;
    if (acc) exp_q.push_back({dest, data});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    full = 1'b0;
    almost_full = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Every injected flit must match the next expected flit, in order.
  always @(negedge clk) begin
    if (reset && write) begin
      if (exp_q.size() == 0) check_eq("spurious_write", 32'(write), 32'd0);
      else check_eq("flit_order", 32'(dataOut), 32'(exp_q.pop_front()));
    end
  end

  // Saturation run on the second instance.
  initial begin
    int sat_writes;
    sat_writes = 0;
    repeat (2) @(negedge clk);
    s_reset = 1'b1;
    for (int c = 0; c < SatBudget; c++) begin
      @(negedge clk);
      if (s_write) begin
        sat_writes++;
        if (sat_writes == 1000)  check_eq("sat_mid", 32'(s_sent_count), 32'd1000);
        if (sat_writes == 65534) check_eq("sat_pre", 32'(s_sent_count), 32'hFFFE);
        if (sat_writes == 65535) check_eq("sat_hit", 32'(s_sent_count), 32'hFFFF);
        if (sat_writes >= SatTarget) break;
      end
    end
    check_eq("sat_writes", 32'(sat_writes), 32'(SatTarget));
    check_eq("sat_stuck", 32'(s_sent_count), 32'hFFFF);
    sat_done = 1'b1;
  end

  initial begin
    logic        acc;
    logic [31:0] mask;
    int          k;
    logic [3:0]  max_cnt;

    // Reset values while reset is held low.
    @(negedge clk);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_data", 32'(dataOut), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_sent", 32'(sent_count), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_state", 32'(dut.r_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;

    // Single word: dest 2, payload 0x0123 -> 0x8123 two cycles later.
    @(negedge clk);
    put_word(2'd2, 14'h0123, acc);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t1_c1_write", 32'(write), 32'd0);
    check_eq("t1_c1_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    check_eq("t1_c2_write", 32'(write), 32'd1);
    check_eq("t1_c2_data", 32'(dataOut), 32'h8123);
    check_eq("t1_c2_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    check_eq("t1_c3_write", 32'(write), 32'd0);
    check_eq("t1_c3_hold", 32'(dataOut), 32'h8123);
    check_eq("t1_c3_sent", 32'(sent_count), 32'd1);
    check_eq("t1_c3_state", 32'(dut.r_state), 32'(IDLE));

    // Burst limit: 10 back-to-back words.
    apply_reset();
    mask = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      mask[c] = write;
      if (c < 10) put_word(2'(c % 4), 14'(14'h0100 + c), acc);
      else in_valid = 1'b0;
    end
    check_eq("t2_pattern", mask, 32'h0000_37BC);
    check_eq("t2_sent", 32'(sent_count), 32'd10);
    check_eq("t2_count", 32'(fifo_count), 32'd0);

    // Backpressure: full for 2 cycles then almost_full for 2.
    apply_reset();
    mask = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mask[c] = write;
      if (c == 5) check_eq("t3_state_hold", 32'(dut.r_state), 32'(HOLD));
      full        = (c == 3) || (c == 4);
      almost_full = (c == 5) || (c == 6);
      if (c < 8) put_word(2'(3 - (c % 4)), 14'(14'h02A0 + c), acc);
      else in_valid = 1'b0;
    end
    check_eq("t3_pattern", mask, 32'h0000_7B0C);
    check_eq("t3_sent", 32'(sent_count), 32'd8);
    check_eq("t3_count", 32'(fifo_count), 32'd0);

    // FIFO fill under almost_full, release at cycle 11.
    apply_reset();
    almost_full = 1'b1;
    k = 0;
    max_cnt = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_count > max_cnt) max_cnt = fifo_count;
      if (c == 8) begin
        check_eq("t4_c8_ready", 32'(in_ready), 32'd0);
        check_eq("t4_c8_count", 32'(fifo_count), 32'd8);
      end
      if (c == 11) begin
        check_eq("t4_c11_ready", 32'(in_ready), 32'd0);
        almost_full = 1'b0;
      end
      if (c == 12) begin
        check_eq("t4_c12_ready", 32'(in_ready), 32'd1);
        check_eq("t4_c12_write", 32'(write), 32'd1);
        check_eq("t4_c12_count", 32'(fifo_count), 32'd7);
      end
      if (c == 13) check_eq("t4_c13_count", 32'(fifo_count), 32'd7);
      if (k < 9) begin
        put_word(2'd1, 14'(14'h3000 + k), acc);
        if (acc) k++;
      end else begin
        in_valid = 1'b0;
      end
    end
    check_eq("t4_accepted", 32'(k), 32'd9);
    check_eq("t4_max_count", 32'(max_cnt), 32'd8);
    check_eq("t4_sent", 32'(sent_count), 32'd9);
    check_eq("t4_count", 32'(fifo_count), 32'd0);

    // Reset mid-stream with 5 flits buffered and write high.
    apply_reset();
    almost_full = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      put_word(2'd0, 14'(14'h00A0 + c), acc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t5_c6_count", 32'(fifo_count), 32'd6);
    almost_full = 1'b0;
    @(negedge clk);
    check_eq("t5_c7_write", 32'(write), 32'd1);
    check_eq("t5_c7_count", 32'(fifo_count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_async_write", 32'(write), 32'd0);
    check_eq("t5_async_count", 32'(fifo_count), 32'd0);
    check_eq("t5_async_sent", 32'(sent_count), 32'd0);
    check_eq("t5_async_data", 32'(dataOut), 32'd0);
    check_eq("t5_async_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) put_word(2'd3, 14'h3FFF, acc);
      else if (c == 1) put_word(2'd0, 14'h0001, acc);
      else if (c == 2) put_word(2'd2, 14'h2222, acc);
      else in_valid = 1'b0;
    end
    check_eq("t5_post_sent", 32'(sent_count), 32'd3);
    check_eq("t5_post_count", 32'(fifo_count), 32'd0);
    check_eq("t5_post_last", 32'(dataOut), 32'hA222);
    check_eq("t5_post_drained", 32'(exp_q.size()), 32'd0);

    // The saturation process is bounded by its own cycle budget.
    wait (sat_done);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
